in_mem_rd_ctrl: RTL and testbench

Read-side sequencer for the input memory banks. It streams the input matrix held in the SYS_ROW banks into the systolic array's row inputs, one chunk of SYS_ROW common-dimension elements at a time. Bank i is issued i cycles after bank 0, which produces the diagonal wavefront the array expects. It uses the same address map as the input write controller, so it consumes the row count that the write controller produces.

---
 rtl/in_mem_pkg.sv | 29 ++
 rtl/in_mem_rd_ctrl_if.sv | 31 +++
 rtl/lane_skew.sv | 33 +++
 rtl/in_mem_rd_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_in_mem_rd_ctrl.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/in_mem_pkg.sv
// Shared definitions for the input-memory read and write controllers.
// Both sides build bank addresses with compose_addr so their maps always agree.
package in_mem_pkg;

  localparam int unsigned CNT_WIDTH = 32;

  typedef logic [CNT_WIDTH-1:0] cnt_t;

  typedef enum logic [1:0] {
    RD_IDLE  = 2'd0,
    RD_READ  = 2'd1,
    RD_DRAIN = 2'd2,
    RD_DONE  = 2'd3
  } rd_state_t;

  // Accumulator rows available per chunk of the address space.
  function automatic int unsigned accum_row(input int unsigned accum_size,
                                            input int unsigned sys_col);
    return accum_size / sys_col;
  endfunction

  // Chunk selects an ACCUM_ROW-sized window, row indexes within it.
  function automatic cnt_t compose_addr(input cnt_t        chunk,
                                        input cnt_t        row,
                                        input int unsigned log2_accum_row);
    return (chunk << log2_accum_row) + row;
  endfunction

endpackage

// File: rtl/in_mem_rd_ctrl_if.sv
// Request, bank-read and array-feed signals of the input read controller.
interface in_mem_rd_ctrl_if
  import in_mem_pkg::*;
#(
  parameter int unsigned SYS_ROW    = 16,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 16
);

  logic                                  start;
  cnt_t                                  num_rows;
  logic [DATA_WIDTH-1:0]                 num_common;
  logic                                  busy;
  logic                                  done;
  logic [SYS_ROW-1:0]                    in_rd_en;
  logic [SYS_ROW-1:0][ADDR_WIDTH-1:0]    in_rd_addr;
  logic [SYS_ROW-1:0][DATA_WIDTH-1:0]    in_rd_data;
  logic [SYS_ROW-1:0]                    out_valid;
  logic [SYS_ROW-1:0][DATA_WIDTH-1:0]    out_data;

  modport master (
    input  start, num_rows, num_common, in_rd_data,
    output busy, done, in_rd_en, in_rd_addr, out_valid, out_data
  );

  modport slave (
    output start, num_rows, num_common, in_rd_data,
    input  busy, done, in_rd_en, in_rd_addr, out_valid, out_data
  );

endinterface

// File: rtl/lane_skew.sv
// Parameterized delay line with synchronous clear; DEPTH=0 is a plain wire.
module lane_skew #(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (DEPTH == 0) begin : g_pass
    logic unused_ctrl;
    assign unused_ctrl = ^{clk, clr};
    assign q = d;
  end else begin : g_pipe
    logic [DEPTH-1:0][WIDTH-1:0] sr;

    always_ff @(posedge clk) begin
      if (clr) begin
        sr <= '0;
      end else begin
        sr[0] <= d;
        for (int unsigned j = 1; j < DEPTH; j++) begin
          sr[j] <= sr[j-1];
        end
      end
    end

    assign q = sr[DEPTH-1];
  end

endmodule

// File: rtl/in_mem_rd_ctrl.sv
// Streams the input matrix out of the SYS_ROW banks chunk by chunk, skewing
// bank i by i cycles so the systolic array sees a diagonal wavefront.
module in_mem_rd_ctrl
  import in_mem_pkg::*;
#(
  parameter int unsigned SYS_ROW    = 16,
  parameter int unsigned SYS_COL    = 16,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned ACCUM_SIZE = 1024,
  parameter int unsigned RD_LATENCY = 1
) (
  input logic              clk,
  input logic              rst,
  in_mem_rd_ctrl_if.master bus
);

  localparam int unsigned LOG2_ROW     = $clog2(SYS_ROW);
  localparam int unsigned ACCUM_ROW    = accum_row(ACCUM_SIZE, SYS_COL);
  localparam int unsigned LOG2_AR      = $clog2(ACCUM_ROW);
  localparam int unsigned DRAIN_CYCLES = SYS_ROW + RD_LATENCY;
  localparam int unsigned LANE_W       = ADDR_WIDTH + 1;

  localparam logic [1:0] ST_IDLE  = RD_IDLE;
  localparam logic [1:0] ST_READ  = RD_READ;
  localparam logic [1:0] ST_DRAIN = RD_DRAIN;
  localparam logic [1:0] ST_DONE  = RD_DONE;

  logic [1:0]            state, state_nxt;
  logic                  busy_q, busy_nxt;
  logic                  done_q, done_nxt;
  logic                  base_en, base_en_nxt;
  logic [ADDR_WIDTH-1:0] base_addr, base_addr_nxt;
  cnt_t                  rows, rows_nxt;
  cnt_t                  chunks, chunks_nxt;
  cnt_t                  k_cnt, k_nxt;
  cnt_t                  r_cnt, r_nxt;
  cnt_t                  drain_cnt, drain_nxt;

  cnt_t req_rows_c;
  cnt_t req_chunks_c;
  logic row_wrap_c;
  logic last_step_c;

  assign req_rows_c   = (bus.num_rows > CNT_WIDTH'(ACCUM_ROW)) ? CNT_WIDTH'(ACCUM_ROW)
                                                               : bus.num_rows;
  assign req_chunks_c = CNT_WIDTH'(bus.num_common >> LOG2_ROW);
  assign row_wrap_c   = (r_cnt == rows - CNT_WIDTH'(1));
  assign last_step_c  = row_wrap_c && (k_cnt == chunks - CNT_WIDTH'(1));

  // Next-state and registered-output logic; wrap is tested before incrementing.
  always_comb begin
    state_nxt     = state;
    busy_nxt      = busy_q;
    done_nxt      = 1'b0;
    base_en_nxt   = 1'b0;
    base_addr_nxt = base_addr;
    rows_nxt      = rows;
    chunks_nxt    = chunks;
    k_nxt         = k_cnt;
    r_nxt         = r_cnt;
    drain_nxt     = drain_cnt;

    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          rows_nxt   = req_rows_c;
          chunks_nxt = req_chunks_c;
          k_nxt      = '0;
          r_nxt      = '0;
          if (req_rows_c == '0 || req_chunks_c == '0) begin
            state_nxt = ST_DONE;
            done_nxt  = 1'b1;
          end else begin
            state_nxt     = ST_READ;
            busy_nxt      = 1'b1;
            base_en_nxt   = 1'b1;
            base_addr_nxt = ADDR_WIDTH'(compose_addr('0, '0, LOG2_AR));
          end
        end
      end

      ST_READ: begin
        if (last_step_c) begin
          state_nxt = ST_DRAIN;
          drain_nxt = '0;
        end else begin
          if (row_wrap_c) begin
            r_nxt = '0;
            k_nxt = k_cnt + CNT_WIDTH'(1);
          end else begin
            r_nxt = r_cnt + CNT_WIDTH'(1);
          end
          base_en_nxt   = 1'b1;
          base_addr_nxt = ADDR_WIDTH'(compose_addr(k_nxt, r_nxt, LOG2_AR));
        end
      end

      // Covers the deepest lane skew plus the read latency and output register.
      ST_DRAIN: begin
        if (drain_cnt == CNT_WIDTH'(DRAIN_CYCLES - 1)) begin
          state_nxt = ST_DONE;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
        end else begin
          drain_nxt = drain_cnt + CNT_WIDTH'(1);
        end
      end

      ST_DONE: state_nxt = ST_IDLE;

      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      base_en   <= 1'b0;
      base_addr <= '0;
      rows      <= '0;
      chunks    <= '0;
      k_cnt     <= '0;
      r_cnt     <= '0;
      drain_cnt <= '0;
    end else begin
      state     <= state_nxt;
      busy_q    <= busy_nxt;
      done_q    <= done_nxt;
      base_en   <= base_en_nxt;
      base_addr <= base_addr_nxt;
      rows      <= rows_nxt;
      chunks    <= chunks_nxt;
      k_cnt     <= k_nxt;
      r_cnt     <= r_nxt;
      drain_cnt <= drain_nxt;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;

  // Per-lane skew of the base request, then latency alignment into the array feed.
  for (genvar i = 0; i < SYS_ROW; i++) begin : g_lane
    logic [LANE_W-1:0]     skew_q;
    logic                  vld_dly;
    logic                  vld_q;
    logic [DATA_WIDTH-1:0] data_q;

    lane_skew #(.DEPTH(i), .WIDTH(LANE_W)) u_skew (
      .clk (clk),
      .clr (rst),
      .d   ({base_en, base_addr}),
      .q   (skew_q)
    );

    lane_skew #(.DEPTH(RD_LATENCY), .WIDTH(1)) u_vld (
      .clk (clk),
      .clr (rst),
      .d   (skew_q[LANE_W-1]),
      .q   (vld_dly)
    );

    always_ff @(posedge clk) begin
      if (rst) begin
        vld_q  <= 1'b0;
        data_q <= '0;
      end else begin
        vld_q <= vld_dly;
        if (vld_dly) data_q <= bus.in_rd_data[i];
      end
    end

    assign bus.in_rd_en[i]   = skew_q[LANE_W-1];
    assign bus.in_rd_addr[i] = skew_q[ADDR_WIDTH-1:0];
    assign bus.out_valid[i]  = vld_q;
    assign bus.out_data[i]   = data_q;
  end

endmodule

// File: tb/tb_in_mem_rd_ctrl.sv
// Directed bench for in_mem_rd_ctrl: table of requests checked cycle by cycle
// against closed-form wavefront timing, plus reset and idle sequences.
module tb_in_mem_rd_ctrl;

  localparam int S  = 4;
  localparam int DW = 16;
  localparam int AW = 16;
  localparam int L  = 1;
  localparam int AR = 16;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  in_mem_rd_ctrl_if #(.SYS_ROW(S), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  in_mem_rd_ctrl #(
    .SYS_ROW    (S),
    .SYS_COL    (4),
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .ACCUM_SIZE (64),
    .RD_LATENCY (L)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Bank b holds addr*16+b; data appears one cycle after the enable.
  always @(posedge clk) begin
    for (int b = 0; b < S; b++) begin
      if (bus.in_rd_en[b])
        bus.in_rd_data[b] <= 16'(32'(bus.in_rd_addr[b]) * 32'd16 + 32'(b));
    end
  end

  typedef struct {
    int rows;
    int common;
    bit spam;
    int rst_at;
    int exp_r;
    int exp_k;
    int exp_done;
  } vec_t;

  vec_t        vecs [10];
  int          n_vec = 0;
  int          n_bad = 0;
  logic [15:0] exp_hold [S];

  task automatic chk(input string nm, input int t, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, t, act, exp);
    end
  endtask

  function automatic int step_addr(input int s, input int r);
    return (s / r) * AR + (s % r);
  endfunction

  task automatic chk_zero(input string tag, input int t);
    chk({tag, " busy"}, t, 32'(bus.busy), 32'd0);
    chk({tag, " done"}, t, 32'(bus.done), 32'd0);
    chk({tag, " en"}, t, 32'(bus.in_rd_en), 32'd0);
    chk({tag, " valid"}, t, 32'(bus.out_valid), 32'd0);
    for (int i = 0; i < S; i++) begin
      chk($sformatf("%s addr%0d", tag, i), t, 32'(bus.in_rd_addr[i]), 32'd0);
      chk($sformatf("%s data%0d", tag, i), t, 32'(bus.out_data[i]), 32'd0);
    end
  endtask

  // Cycle 0 is the edge that samples start; outputs checked mid-cycle.
  task automatic run_vec(input int idx, input vec_t v);
    int          n, t_end, s;
    bit          degen;
    logic [31:0] e_en, e_ov;
    string       tag;
    n     = v.exp_r * v.exp_k;
    degen = (n == 0);
    t_end = (v.rst_at > 0) ? v.rst_at + 4 : v.exp_done;
    tag   = $sformatf("v%0d", idx);
    @(negedge clk);
    bus.num_rows   = 32'(v.rows);
    bus.num_common = 16'(v.common);
    bus.start      = 1'b1;
    for (int t = 1; t <= t_end; t++) begin
      @(negedge clk);
      if (v.rst_at > 0 && t > v.rst_at) begin
        for (int i = 0; i < S; i++) exp_hold[i] = '0;
        chk_zero({tag, " post-rst"}, t);
      end else begin
        chk({tag, " busy"}, t, 32'(bus.busy), 32'(!degen && t < v.exp_done));
        chk({tag, " done"}, t, 32'(bus.done), 32'(t == v.exp_done));
        e_en = '0;
        e_ov = '0;
        for (int i = 0; i < S; i++) begin
          if (!degen && t >= 1 + i && t <= n + i) begin
            e_en[i] = 1'b1;
            s = t - 1 - i;
            chk($sformatf("%s addr%0d", tag, i), t, 32'(bus.in_rd_addr[i]),
                32'(step_addr(s, v.exp_r)));
          end
          if (!degen && t >= 2 + i + L && t <= n + 1 + i + L) begin
            e_ov[i] = 1'b1;
            s = t - 2 - i - L;
            exp_hold[i] = 16'(step_addr(s, v.exp_r) * 16 + i);
          end
          chk($sformatf("%s data%0d", tag, i), t, 32'(bus.out_data[i]), 32'(exp_hold[i]));
        end
        chk({tag, " en"}, t, 32'(bus.in_rd_en), e_en);
        chk({tag, " valid"}, t, 32'(bus.out_valid), e_ov);
      end
      rst       = (v.rst_at > 0 && t == v.rst_at);
      bus.start = v.spam && t >= 2 && t <= 10;
      if (v.spam && t >= 2 && t <= 10) begin
        bus.num_rows   = 32'd9;
        bus.num_common = 16'd20;
      end else begin
        bus.num_rows   = 32'(v.rows);
        bus.num_common = 16'(v.common);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    // rows, common, spam, rst_at, exp R, exp K, exp done cycle
    vecs[0] = '{3,  8,  1'b0, 0, 3,  2, 12};  // basic stream
    vecs[1] = '{3,  3,  1'b0, 0, 3,  0, 1};   // K == 0
    vecs[2] = '{0,  8,  1'b0, 0, 0,  2, 1};   // R == 0
    vecs[3] = '{20, 4,  1'b0, 0, 16, 1, 22};  // row clamp
    vecs[4] = '{3,  8,  1'b0, 5, 3,  2, 12};  // reset in cycle 5
    vecs[5] = '{3,  8,  1'b0, 0, 3,  2, 12};  // replay after reset
    vecs[6] = '{3,  8,  1'b1, 0, 3,  2, 12};  // starts/inputs change while running
    vecs[7] = '{3,  8,  1'b0, 0, 3,  2, 12};  // back-to-back after done
    vecs[8] = '{2,  12, 1'b0, 0, 2,  3, 12};  // three chunks
    vecs[9] = '{1,  4,  1'b0, 0, 1,  1, 7};   // single step

    rst            = 1'b1;
    bus.start      = 1'b0;
    bus.num_rows   = '0;
    bus.num_common = '0;
    for (int i = 0; i < S; i++) exp_hold[i] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_zero("reset", 0);
    rst = 1'b0;

    for (int v = 0; v < 10; v++) run_vec(v, vecs[v]);

    // Controller must settle idle with held data after the last run.
    for (int t = 1; t <= 3; t++) begin
      @(negedge clk);
      chk("idle busy", t, 32'(bus.busy), 32'd0);
      chk("idle done", t, 32'(bus.done), 32'd0);
      chk("idle en", t, 32'(bus.in_rd_en), 32'd0);
      chk("idle valid", t, 32'(bus.out_valid), 32'd0);
      chk("idle data3", t, 32'(bus.out_data[3]), 32'(exp_hold[3]));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
